// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-requester I2C transaction arbiter.
package i2c_pkg;
  localparam int NUM_REQ    = 2;
  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESP,
    DRAIN
  } arb_state_t;
endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and i2c_master-side signals of the arbiter, bundled as one interface.
interface i2c_txn_arbiter_if;
  import i2c_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0][I2C_ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]                 req_rw;
  logic [NUM_REQ-1:0][7:0]            req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [7:0]                         rsp_data;
  logic                               rsp_ack_err;
  logic                               rsp_timeout;
  logic                               arb_busy;

  logic                  m_start;
  logic [I2C_ADDR_W-1:0] m_slave_addr;
  logic                  m_rw_bit;
  logic [7:0]            m_tx_data;
  logic                  m_busy;
  logic                  m_done;
  logic                  m_ack_error;
  logic [7:0]            m_rx_data;

  // Arbiter view
  modport slave (
    input  req_valid, req_addr, req_rw, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_ack_err, rsp_timeout, arb_busy,
    output m_start, m_slave_addr, m_rw_bit, m_tx_data,
    input  m_busy, m_done, m_ack_error, m_rx_data
  );

  // Requesters plus master stub view
  modport master (
    output req_valid, req_addr, req_rw, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_ack_err, rsp_timeout, arb_busy,
    input  m_start, m_slave_addr, m_rw_bit, m_tx_data,
    output m_busy, m_done, m_ack_error, m_rx_data
  );
endinterface

// File: rtl/i2c_rr_arbiter.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module i2c_rr_arbiter
  import i2c_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               update,
  output logic               grant,
  output logic [NUM_REQ-1:0] grant_oh
);
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = 1'b0;
    if (&req_valid) grant = ~last_grant_q;
    else            grant = req_valid[1];
    last_grant_d = update ? grant : last_grant_q;
  end

  assign grant_oh = {grant, ~grant};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master between two requesters: round-robin accept, start/done
// sequencing with a done-timeout, and response routing back to the owner.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input logic              clk,
  input logic              rst_n,
  i2c_txn_arbiter_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_t            state_q;
  logic [TO_W-1:0]       cnt_q;
  logic                  owner_q;
  logic                  m_start_q;
  logic [I2C_ADDR_W-1:0] m_addr_q;
  logic                  m_rw_q;
  logic [7:0]            m_tx_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [7:0]            rsp_data_q;
  logic                  rsp_ack_err_q;
  logic                  rsp_timeout_q;

  logic               accept;
  logic               gnt;
  logic [NUM_REQ-1:0] gnt_oh;

  assign accept = (state_q == IDLE) && (|bus.req_valid);

  i2c_rr_arbiter u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.req_valid),
    .update    (accept),
    .grant     (gnt),
    .grant_oh  (gnt_oh)
  );

  assign bus.req_ready    = accept ? gnt_oh : '0;
  assign bus.arb_busy     = (state_q != IDLE);
  assign bus.m_start      = m_start_q;
  assign bus.m_slave_addr = m_addr_q;
  assign bus.m_rw_bit     = m_rw_q;
  assign bus.m_tx_data    = m_tx_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_ack_err  = rsp_ack_err_q;
  assign bus.rsp_timeout  = rsp_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      m_start_q     <= 1'b0;
      m_addr_q      <= '0;
      m_rw_q        <= 1'b0;
      m_tx_q        <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_ack_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      m_start_q   <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            m_addr_q  <= bus.req_addr[gnt];
            m_rw_q    <= bus.req_rw[gnt];
            m_tx_q    <= bus.req_data[gnt];
            owner_q   <= gnt;
            m_start_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt_q <= cnt_q + 1'b1;
          // m_done has priority over an expiring timeout in the same cycle
          if (bus.m_done) begin
            rsp_data_q           <= bus.m_rx_data;
            rsp_ack_err_q        <= bus.m_ack_error;
            rsp_timeout_q        <= 1'b0;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= RESP;
          end else if (cnt_q == TO_LAST) begin
            rsp_data_q           <= '0;
            rsp_ack_err_q        <= 1'b1;
            rsp_timeout_q        <= 1'b1;
            rsp_valid_q[owner_q] <= 1'b1;
            state_q              <= RESP;
          end
        end
        RESP: begin
          state_q <= bus.m_busy ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (!bus.m_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench: expected grants/responses are queued at stimulus time and
// popped by a negedge monitor; a behavioural master stub answers m_start.
module tb_i2c_txn_arbiter;
  import i2c_pkg::*;

  localparam int TO = 16;

  typedef struct {
    logic       owner;
    logic [7:0] data;
    logic       ack;
    logic       to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if bus();

  i2c_txn_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rsp_t sb[$];
  logic exp_own_q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, acc_cnt = 0, rsp_cnt = 0;
  int   acc_cyc = -10, start_cyc = -10, done_cyc = -10;
  logic cur_own = 1'b0;

  logic [6:0] t_addr[2];
  logic [7:0] t_data[2];
  logic       t_rw[2];

  int         st_delay = 4;
  logic [7:0] st_rx = 8'h00;
  logic       st_nack = 1'b0;
  bit         st_nodone = 1'b0;

  // Monitor
  initial begin
    rsp_t e;
    int   exp_c;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (|(bus.req_valid & bus.req_ready)) begin
          acc_cnt++; acc_cyc = cyc; n_chk++;
          if (exp_own_q.size() == 0) begin
            $display("FAIL accept_unexpected req_ready=%b", bus.req_ready);
          end else begin
            cur_own = exp_own_q.pop_front();
            if (bus.req_ready !== (2'b01 << cur_own))
              $display("FAIL grant req_ready=%b exp=%b", bus.req_ready, 2'b01 << cur_own);
            else n_pass++;
          end
        end
        if (bus.m_start) begin
          start_cyc = cyc; n_chk++;
          if (cyc !== acc_cyc + 1 || bus.m_slave_addr !== t_addr[cur_own] ||
              bus.m_tx_data !== t_data[cur_own] || bus.m_rw_bit !== t_rw[cur_own])
            $display("FAIL m_start cyc=%0d exp=%0d addr=%h/%h data=%h/%h rw=%b/%b",
                     cyc, acc_cyc + 1, bus.m_slave_addr, t_addr[cur_own],
                     bus.m_tx_data, t_data[cur_own], bus.m_rw_bit, t_rw[cur_own]);
          else n_pass++;
        end
        if (bus.rsp_valid != '0) begin
          rsp_cnt++; n_chk++;
          if (sb.size() == 0) begin
            $display("FAIL rsp_unexpected rsp_valid=%b", bus.rsp_valid);
          end else begin
            e = sb.pop_front();
            exp_c = e.to ? start_cyc + TO + 1 : done_cyc + 1;
            if (bus.rsp_valid !== (2'b01 << e.owner) || bus.rsp_data !== e.data ||
                bus.rsp_ack_err !== e.ack || bus.rsp_timeout !== e.to || cyc !== exp_c)
              $display("FAIL rsp got v=%b d=%h ack=%b to=%b cyc=%0d exp v=%b d=%h ack=%b to=%b cyc=%0d",
                       bus.rsp_valid, bus.rsp_data, bus.rsp_ack_err, bus.rsp_timeout, cyc,
                       2'b01 << e.owner, e.data, e.ack, e.to, exp_c);
            else n_pass++;
          end
        end
        if (bus.m_done && bus.arb_busy) done_cyc = cyc;
      end
    end
  end

  // i2c_master stub
  initial begin
    int k;
    bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_ack_error = 1'b0; bus.m_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_start) begin
        bus.m_busy = 1'b1;
        k = 0;
        if (st_nodone) begin
          while (k < TO + 6 && rst_n) begin @(posedge clk); #1; k++; end
          if (rst_n) begin
            bus.m_done = 1'b1; bus.m_rx_data = 8'hEE; bus.m_ack_error = 1'b0;
            @(posedge clk); #1;
            bus.m_done = 1'b0;
            repeat (3) @(posedge clk);
            #1;
          end
        end else begin
          while (k < st_delay && rst_n) begin @(posedge clk); #1; k++; end
          if (rst_n) begin
            bus.m_done = 1'b1; bus.m_rx_data = st_rx; bus.m_ack_error = st_nack;
            @(posedge clk); #1;
          end
        end
        bus.m_done = 1'b0;
        bus.m_busy = 1'b0;
      end
    end
  end

  task automatic set_req(input int r, input logic [6:0] a, input logic rw, input logic [7:0] d);
    t_addr[r] = a; t_data[r] = d; t_rw[r] = rw;
    bus.req_addr[r] = a; bus.req_data[r] = d; bus.req_rw[r] = rw;
  endtask

  task automatic push_rsp(input logic own, input logic [7:0] d, input logic ack, input logic to);
    rsp_t e;
    e.owner = own; e.data = d; e.ack = ack; e.to = to;
    sb.push_back(e);
  endtask

  task automatic issue_req(input logic [1:0] mask, input int n_acc);
    int a0, k;
    a0 = acc_cnt; k = 0;
    @(posedge clk); #1;
    bus.req_valid = mask;
    while (acc_cnt < a0 + n_acc && k < 400) begin @(negedge clk); k++; end
    if (acc_cnt < a0 + n_acc) begin
      n_chk++;
      $display("FAIL accept_timeout accepts=%0d exp=%0d", acc_cnt - a0, n_acc);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_cnt < n && k < 200) begin @(negedge clk); k++; end
    if (rsp_cnt < n) begin
      n_chk++;
      $display("FAIL rsp_timeout_wait got=%0d exp=%0d", rsp_cnt, n);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.arb_busy && k < 200) begin @(negedge clk); k++; end
    n_chk++;
    if (bus.arb_busy) $display("FAIL idle arb_busy=%b exp=0", bus.arb_busy);
    else n_pass++;
  endtask

  task automatic run_txn(input int r, input logic [6:0] a, input logic rw, input logic [7:0] d,
                         input int dly, input logic [7:0] rx, input logic nack, input logic exp_to);
    int n0;
    set_req(r, a, rw, d);
    st_delay = dly; st_rx = rx; st_nack = nack;
    exp_own_q.push_back(r[0]);
    push_rsp(r[0], exp_to ? 8'h00 : rx, exp_to ? 1'b1 : nack, exp_to);
    n0 = rsp_cnt;
    issue_req(2'b01 << r, 1);
    wait_rsp(n0 + 1);
    wait_idle();
  endtask

  task automatic check_zero(input string tag);
    n_chk++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_ack_err, bus.rsp_timeout, bus.arb_busy} !== '0)
      $display("FAIL %s_rsp v=%b d=%h ack=%b to=%b busy=%b exp all 0", tag,
               bus.rsp_valid, bus.rsp_data, bus.rsp_ack_err, bus.rsp_timeout, bus.arb_busy);
    else n_pass++;
    n_chk++;
    if ({bus.m_start, bus.m_slave_addr, bus.m_rw_bit, bus.m_tx_data, bus.req_ready} !== '0)
      $display("FAIL %s_master start=%b addr=%h rw=%b tx=%h rdy=%b exp all 0", tag,
               bus.m_start, bus.m_slave_addr, bus.m_rw_bit, bus.m_tx_data, bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    run_txn(0, 7'h48, 1'b0, 8'hA5, 10, 8'h11, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    run_txn(1, 7'h50, 1'b1, 8'h00, 12, 8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n0;
    set_req(0, 7'h21, 1'b0, 8'h0F);
    set_req(1, 7'h62, 1'b1, 8'hF0);
    st_delay = 3; st_rx = 8'h5D; st_nack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_own_q.push_back(i[0]);
      push_rsp(i[0], 8'h5D, 1'b0, 1'b0);
    end
    n0 = rsp_cnt;
    issue_req(2'b11, 4);
    wait_rsp(n0 + 4);
    wait_idle();
  endtask

  task automatic test_nack();
    run_txn(1, 7'h2A, 1'b0, 8'h5A, 8, 8'h77, 1'b1, 1'b0);
  endtask

  task automatic test_timeout_drain();
    int n0, k;
    set_req(0, 7'h33, 1'b1, 8'h44);
    st_nodone = 1'b1;
    exp_own_q.push_back(1'b0);
    push_rsp(1'b0, 8'h00, 1'b1, 1'b1);
    n0 = rsp_cnt;
    issue_req(2'b01, 1);
    wait_rsp(n0 + 1);
    k = 0;
    while (cyc < start_cyc + TO + 4 && k < 50) begin @(negedge clk); k++; end
    n_chk++;
    if (bus.arb_busy !== 1'b1) $display("FAIL drain_hold arb_busy=%b exp=1", bus.arb_busy);
    else n_pass++;
    wait_idle();
    repeat (5) @(negedge clk);
    n_chk++;
    if (rsp_cnt !== n0 + 1) $display("FAIL late_done rsp_count=%0d exp=%0d", rsp_cnt, n0 + 1);
    else n_pass++;
    st_nodone = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    run_txn(1, 7'h0C, 1'b1, 8'h00, TO, 8'hC3, 1'b0, 1'b0);
    run_txn(0, 7'h0D, 1'b1, 8'h00, TO + 1, 8'h99, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n0;
    set_req(0, 7'h7E, 1'b0, 8'hB6);
    st_delay = 12; st_rx = 8'h12; st_nack = 1'b0;
    exp_own_q.push_back(1'b0);
    n0 = rsp_cnt;
    issue_req(2'b01, 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    n_chk++;
    if (rsp_cnt !== n0) $display("FAIL reset_no_rsp rsp_count=%0d exp=%0d", rsp_cnt, n0);
    else n_pass++;
    // both valid after reset: requester 0 must win the tie
    set_req(1, 7'h19, 1'b0, 8'h3E);
    st_delay = 4; st_rx = 8'h6A;
    exp_own_q.push_back(1'b0);
    push_rsp(1'b0, 8'h6A, 1'b0, 1'b0);
    issue_req(2'b11, 1);
    wait_rsp(n0 + 1);
    wait_idle();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_data = '0;
    for (int i = 0; i < 2; i++) begin t_addr[i] = '0; t_data[i] = '0; t_rw[i] = 1'b0; end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_nack();
    test_timeout_drain();
    test_timeout_boundary();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0 || exp_own_q.size() != 0)
      $display("FAIL leftover sb=%0d grants=%0d exp=0", sb.size(), exp_own_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
